// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: one word per tx handshake, frames end on tx_last_i.
// Optional macro SPI_MASTER_LOOPBACK_EN samples mosi_o internally instead of miso_i.
module spi_master_multi #(
  parameter int NUM_CS = 3,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_cpol_i,
  input  logic              cfg_cpha_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_last_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_last_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_no,
  output logic              busy_o,
  output logic              err_o
);

  localparam int TG_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, WAIT_NEXT, CS_HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_cnt;
  logic [TG_W-1:0]     tgl_cnt;
  logic [CS_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]   tx_sr, rx_sr, rx_next, rx_data_q;
  logic [NUM_CS-1:0]   cs_no_q;
  logic                cpol_q, cpha_q, last_q, sclk_q, mosi_q;
  logic                ready_q, rx_valid_q, rx_last_q, err_q;
  logic                accept, tick, cs_ok, start, load, cpha_eff;
  logic                shift_tick, final_tgl, odd_tgl, sample_now, shift_now, rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso_i;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = miso_i;
`endif

  assign accept     = tx_valid_i && ready_q;
  assign tick       = (div_cnt == div_q);
  assign cs_ok      = 32'(cs_sel_i) < 32'(NUM_CS);
  assign start      = accept && (state_q == IDLE) && cs_ok;
  assign load       = start || (accept && (state_q == WAIT_NEXT));
  assign cpha_eff   = start ? cfg_cpha_i : cpha_q;
  assign sel_d      = start ? cs_sel_i : sel_q;
  assign shift_tick = (state_q == SHIFT) && tick;
  assign final_tgl  = shift_tick && (tgl_cnt == TG_W'(2 * DATA_W - 1));
  // tgl_cnt counts completed toggles, so an even count means the next toggle is odd (leading)
  assign odd_tgl    = ~tgl_cnt[0];
  assign sample_now = shift_tick && (odd_tgl ^ cpha_q);
  // CPHA=0 skips the shift on the final trailing edge so mosi_o holds the LSB between words
  assign shift_now  = shift_tick && !(odd_tgl ^ cpha_q) && !final_tgl;
  assign rx_next    = sample_now ? {rx_sr[DATA_W-2:0], rx_bit} : rx_sr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)     state_d = CS_SETUP;
      CS_SETUP:  if (tick)      state_d = SHIFT;
      SHIFT:     if (final_tgl) state_d = last_q ? CS_HOLD : WAIT_NEXT;
      WAIT_NEXT: if (accept)    state_d = SHIFT;
      CS_HOLD:   if (tick)      state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= '0;
      div_cnt    <= '0;
      tgl_cnt    <= '0;
      sel_q      <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      cs_no_q    <= '1;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q    <= (state_d == IDLE) || (state_d == WAIT_NEXT);
      err_q      <= accept && (state_q == IDLE) && !cs_ok;
      rx_valid_q <= final_tgl;
      cs_no_q    <= (state_d == IDLE) ? '1 : ~(NUM_CS'(1) << sel_d);
      if ((state_q == IDLE) || (state_q == WAIT_NEXT) || tick) div_cnt <= '0;
      else                                                   div_cnt <= div_cnt + DIV_W'(1);
      if (start) begin
        cpol_q <= cfg_cpol_i;
        cpha_q <= cfg_cpha_i;
        div_q  <= cfg_div_i;
        sel_q  <= cs_sel_i;
        sclk_q <= cfg_cpol_i;
      end
      if (load) begin
        last_q  <= tx_last_i;
        tgl_cnt <= '0;
        rx_sr   <= '0;
        if (!cpha_eff) begin
          mosi_q <= tx_data_i[DATA_W-1];
          tx_sr  <= tx_data_i << 1;
        end else begin
          tx_sr  <= tx_data_i;
        end
      end else if (shift_tick) begin
        sclk_q  <= ~sclk_q;
        tgl_cnt <= final_tgl ? '0 : tgl_cnt + TG_W'(1);
        rx_sr   <= rx_next;
        if (shift_now) begin
          mosi_q <= tx_sr[DATA_W-1];
          tx_sr  <= tx_sr << 1;
        end
      end
      if (final_tgl) begin
        rx_data_q <= rx_next;
        rx_last_q <= last_q;
      end
    end
  end

  assign tx_ready_o = ready_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign rx_last_o  = rx_last_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign cs_no      = cs_no_q;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: table of single-word frames against a behavioural
// SPI slave, plus burst, bad-select and mid-frame reset sequences.
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0;
  logic [7:0] cfg_div = '0;
  logic [1:0] cs_sel = '0;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, rx_valid, rx_last, sclk, mosi, miso, busy, err;
  logic [7:0] rx_data;
  logic [2:0] cs_n;

  logic        tb_lb = 1'b0, tb_cpol = 1'b0, tb_cpha = 1'b0;
  logic        slv_miso = 1'b0;
  logic [31:0] slv_sr = '0;

  assign miso = tb_lb ? mosi : slv_miso;

  spi_master_multi #(.NUM_CS(3), .DATA_W(8), .DIV_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha),
    .cfg_div_i(cfg_div), .cs_sel_i(cs_sel), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_data_i(tx_data), .tx_last_i(tx_last), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .rx_last_o(rx_last), .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_no(cs_n),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [1:0] cs;
    logic [7:0] data;
    logic [7:0] slave;
    logic       lb;
    logic [7:0] exp_rx;
    int         exp_len;
  } vec_t;

  typedef struct { logic [7:0] d; logic l; } rx_t;
  typedef struct { int len; int tgl; logic [2:0] pat; logic cpol; } frm_t;

  rx_t  rx_q[$];
  frm_t exp_frm[$];
  int   n_chk = 0, n_err = 0;
  int   n_rx = 0, n_errp = 0, n_frames = 0, tgl_seen = 0, frm_cyc = 0;
  logic frame_abort = 1'b0, prev_low = 1'b0, prev_sclk = 1'b0, cs_low;
  vec_t vecs[6];
  vec_t v_post;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: actual=event missing required=event seen", name);
  endtask

  // Behavioural slave: CPHA=0 drives on CS fall and trailing edges, CPHA=1 on leading edges
  always @(posedge clk) begin
    #1;
    cs_low = (cs_n != 3'b111);
    if (cs_low && !prev_low) begin
      n_frames++;
      frm_cyc  = 1;
      tgl_seen = 0;
      if (exp_frm.size() == 0) fail_now("cs_unexpected");
      else begin
        chk("cs_pattern", 32'(cs_n), 32'(exp_frm[0].pat));
        chk("sclk_idle", 32'(sclk), 32'(exp_frm[0].cpol));
      end
      if (!tb_cpha) begin slv_miso = slv_sr[31]; slv_sr = slv_sr << 1; end
    end else if (cs_low) begin
      frm_cyc++;
      if (sclk != prev_sclk) begin
        tgl_seen++;
        if ((sclk != tb_cpol) == tb_cpha) begin slv_miso = slv_sr[31]; slv_sr = slv_sr << 1; end
      end
    end else if (prev_low) begin
      if (frame_abort) frame_abort = 1'b0;
      else if (exp_frm.size() == 0) fail_now("frame_expectation");
      else begin
        frm_t e;
        e = exp_frm.pop_front();
        if (e.len != 0) chk("cs_low_cycles", 32'(frm_cyc), 32'(e.len));
        chk("sclk_toggles", 32'(tgl_seen), 32'(e.tgl));
      end
    end
    prev_low  = cs_low;
    prev_sclk = sclk;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cs_onehot", 32'($countones(~cs_n) <= 1), 32'(1));
      if (rx_valid) begin
        n_rx++;
        if (rx_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL rx_unexpected: actual=rx_valid data %0h required=no rx_valid", rx_data);
        end else begin
          rx_t e;
          e = rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.d));
          chk("rx_last", 32'(rx_last), 32'(e.l));
        end
      end
      if (err) n_errp++;
    end
  end

  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) fail_now("tx_ready_timeout");
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 5000);
    if (n >= 5000) fail_now("busy_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    cfg_cpol = v.cpol; cfg_cpha = v.cpha; cfg_div = v.div; cs_sel = v.cs;
    tb_cpol = v.cpol;  tb_cpha = v.cpha;  tb_lb = v.lb;
    slv_sr = {v.slave, 24'h0};
    exp_frm.push_back(frm_t'{v.exp_len, 16, ~(3'b001 << v.cs), v.cpol});
    rx_q.push_back(rx_t'{v.exp_rx, 1'b1});
    send_word(v.data, 1'b1);
    wait_idle();
  endtask

  task automatic chk_reset(input string name);
    chk(name, {22'h0, cs_n, sclk, mosi, tx_ready, rx_valid, rx_last, busy, err},
        {22'h0, 3'b111, 7'b0});
    chk({name, "_rx_data"}, 32'(rx_data), 32'h0);
  endtask

  initial begin
    int n, e0, f0, r0;
    vecs[0] = '{1'b0, 1'b0, 8'd1, 2'd0, 8'hA5, 8'h00, 1'b1, 8'hA5, 36};
    vecs[1] = '{1'b1, 1'b1, 8'd0, 2'd0, 8'h96, 8'h3C, 1'b0, 8'h3C, 18};
    vecs[2] = '{1'b0, 1'b1, 8'd2, 2'd1, 8'h5A, 8'hC3, 1'b0, 8'hC3, 54};
    vecs[3] = '{1'b1, 1'b0, 8'd0, 2'd2, 8'h0F, 8'h81, 1'b0, 8'h81, 18};
    vecs[4] = '{1'b0, 1'b0, 8'd3, 2'd2, 8'h33, 8'h7E, 1'b0, 8'h7E, 72};
    vecs[5] = '{1'b1, 1'b1, 8'd1, 2'd1, 8'h69, 8'h00, 1'b1, 8'h69, 36};
    v_post  = '{1'b0, 1'b0, 8'd1, 2'd2, 8'hC9, 8'h4B, 1'b0, 8'h4B, 36};

    #12 chk_reset("reset_state");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(tx_ready), 32'(0));
    @(posedge clk) #1 chk("ready_first_edge", 32'(tx_ready), 32'(1));

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Two-word burst; config changes during WAIT_NEXT must not affect the frame
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd1; cs_sel = 2'd1;
    tb_cpol = 1'b0;  tb_cpha = 1'b0;  tb_lb = 1'b0;
    slv_sr = {8'hC5, 8'h1E, 16'h0};
    exp_frm.push_back(frm_t'{0, 32, 3'b101, 1'b0});
    rx_q.push_back(rx_t'{8'hC5, 1'b0});
    rx_q.push_back(rx_t'{8'h1E, 1'b1});
    send_word(8'h12, 1'b0);
    n = 0;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) fail_now("wait_next_timeout");
    repeat (5) @(negedge clk);
    chk("burst_cs_held", 32'(cs_n), 32'(3'b101));
    chk("burst_sclk_idle", 32'(sclk), 32'(0));
    chk("burst_busy", 32'(busy), 32'(1));
    chk("burst_rx_count", 32'(n_rx), 32'(7));
    cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_div = 8'd0; cs_sel = 2'd0;
    send_word(8'h34, 1'b1);
    wait_idle();
    chk("burst_rx_total", 32'(n_rx), 32'(8));

    // Out-of-range chip select
    e0 = n_errp; f0 = n_frames; r0 = n_rx;
    cs_sel = 2'd3;
    send_word(8'hFF, 1'b1);
    repeat (6) @(negedge clk);
    chk("err_pulse_cycles", 32'(n_errp - e0), 32'(1));
    chk("err_no_frame", 32'(n_frames - f0), 32'(0));
    chk("err_no_rx", 32'(n_rx - r0), 32'(0));
    chk("err_cs_idle", 32'(cs_n), 32'(3'b111));
    chk("err_ready", 32'({busy, tx_ready}), 32'(2'b01));

    // Reset after toggle 7 of a word
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd1; cs_sel = 2'd0;
    tb_cpol = 1'b0;  tb_cpha = 1'b0;  tb_lb = 1'b0;
    slv_sr = 32'hF0F0_0000;
    exp_frm.push_back(frm_t'{0, 0, 3'b110, 1'b0});
    r0 = n_rx;
    send_word(8'h5A, 1'b1);
    n = 0;
    while (tgl_seen < 7 && n < 2000) begin @(posedge clk); #2; n++; end
    if (n >= 2000) fail_now("toggle7_timeout");
    frame_abort = 1'b1;
    exp_frm.delete();
    rst_n = 1'b0;
    #1 chk_reset("midframe_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(tx_ready), 32'(0));
    @(posedge clk) #1 chk("ready_edge_after_reset", 32'(tx_ready), 32'(1));
    repeat (4) @(negedge clk);
    chk("reset_no_rx", 32'(n_rx - r0), 32'(0));
    run_frame(v_post);

    chk("rx_queue_drained", 32'(rx_q.size()), 32'(0));
    chk("frame_queue_drained", 32'(exp_frm.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter NUM_CS, default 3, number of chip-select lines (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, bits per word (4..32).
REQ-003 SHALL have parameter DIV_W, default 8, width of the clock-divider field.
REQ-004 SHALL have port clk_i  in  1  base clock; the block uses one clock only.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cfg_cpol_i/cfg_cpha_i  in  1 each  SPI mode, sampled on word acceptance in IDLE.
REQ-007 SHALL have port cfg_div_i  in  DIV_W  half-period = cfg_div_i+1 clk_i cycles, sampled on acceptance in IDLE.
REQ-008 SHALL have port cs_sel_i  in  $clog2(NUM_CS) (min 1)  target slave index, sampled on acceptance in IDLE.
REQ-009 SHALL have ports tx_valid_i in 1, tx_ready_o out 1, tx_data_i in DATA_W, tx_last_i in 1  word-in handshake; tx_last_i ends the frame.
REQ-010 SHALL have ports rx_valid_o out 1, rx_data_o out DATA_W, rx_last_o out 1  received word, no backpressure.
REQ-011 SHALL have ports sclk_o out 1, mosi_o out 1, miso_i in 1, cs_no out NUM_CS (active-low).
REQ-012 SHALL have ports busy_o out 1 (state != IDLE) and err_o out 1 (one-cycle error pulse).

Function
REQ-013 SHALL implement FSM states IDLE, CS_SETUP, SHIFT, WAIT_NEXT, CS_HOLD.
REQ-014 A transfer SHALL occur only on a cycle where tx_valid_i and tx_ready_o are both 1; tx_ready_o SHALL be 1 only in IDLE and WAIT_NEXT.
REQ-015 On acceptance in IDLE, the block SHALL latch the mode, divider and cs_sel_i, and enter CS_SETUP with cs_no[cs_sel] low from the next cycle.
REQ-016 CS_SETUP SHALL last one half-period, then enter SHIFT.
REQ-017 SHIFT SHALL produce 2*DATA_W sclk_o toggles, one per half-period, with sclk_o idling at the latched CPOL.
REQ-018 Data SHALL be MSB first; with CPHA=0, mosi_o SHALL present the MSB at CS_SETUP entry, and miso_i SHALL be sampled on odd (leading) toggles with shifting on even (trailing) toggles.
REQ-019 With CPHA=1, the block SHALL shift on odd toggles and sample on even toggles.
REQ-020 rx_valid_o SHALL pulse for one cycle, the cycle after the final toggle of each word, carrying rx_data_o and rx_last_o = that word's tx_last_i.
REQ-021 After a word with tx_last_i=0, the block SHALL enter WAIT_NEXT, holding CS asserted, sclk_o at CPOL and mosi_o stable.
REQ-022 On acceptance in WAIT_NEXT, the block SHALL load the next word and go to SHIFT the next cycle; mode, divider and cs_sel changes SHALL be ignored.
REQ-023 After a word with tx_last_i=1, the block SHALL hold CS_HOLD for one half-period, deassert all cs_no, and return to IDLE; tx_ready_o SHALL return to 1 the cycle after the return.
REQ-024 If cs_sel_i >= NUM_CS on acceptance in IDLE, the block SHALL discard the word, pulse err_o, stay in IDLE, and generate no SCLK, CS or rx_valid_o activity.
REQ-025 At most one cs_no bit SHALL be low at any time.
REQ-026 An internal bit counter SHALL wrap to 0 at the end of each word; cfg_div_i=0 SHALL give sclk_o = clk_i/2.

Reset
REQ-027 Asserting rst_ni low SHALL immediately set state to IDLE, cs_no to all ones, sclk_o=0, mosi_o=0, tx_ready_o=0, rx_valid_o=0, rx_last_o=0, rx_data_o=0, busy_o=0 and err_o=0.
REQ-028 tx_ready_o SHALL rise on the first clk_i edge after rst_ni deasserts.
REQ-029 Reset mid-frame SHALL abort with no rx_valid_o for the partial word.

Configuration
REQ-030 When macro SPI_MASTER_LOOPBACK_EN is defined, the block SHALL sample mosi_o internally instead of miso_i, and miso_i SHALL be ignored.
REQ-031 When SPI_MASTER_LOOPBACK_EN is undefined, the block SHALL sample miso_i; all other behaviour SHALL be identical in both cases.

Verification
REQ-032 With DATA_W=8, div=1, mode 0 and loopback, sending tx 0xA5 last -> rx_data_o 0xA5 with rx_last_o=1; cs_no[0] low for 2+32+2 clk_i cycles.
REQ-033 Mode 3 (CPOL=1, CPHA=1), div=0, miso driven with 0x3C -> sclk_o idles 1, rx 0x3C, and 16 toggles occur.
REQ-034 Two-word burst 0x12 (last=0) then 0x34 (last=1) with a 5-cycle gap -> cs_no stays low through WAIT_NEXT, and two rx_valid_o pulses occur with rx_last_o 0 then 1.
REQ-035 cs_sel_i=3 with NUM_CS=3 -> err_o pulses once, cs_no stays 3'b111, and no rx_valid_o occurs.
REQ-036 rst_ni low after toggle 7 of a word -> cs_no goes all ones asynchronously and no rx_valid_o occurs; a new frame afterwards completes correctly.
